// File: rtl/prescaler_prog_pkg.sv
// Shared definitions for the programmable prescaler.
//   mode_e  : clk_out source select (square wave or tick pulse)
//   DIV_MIN : smallest legal divisor; smaller writes clamp to it
package prescaler_prog_pkg;

   typedef enum logic {
      MODE_SQUARE = 1'b0,
      MODE_TICK   = 1'b1
   } mode_e;

   localparam int unsigned DIV_MIN = 2;

endpackage : prescaler_prog_pkg

// File: rtl/prescaler_div_shadow.sv
// Shadowed divisor register for the programmable prescaler.
// A write lands in div_nxt (clamped to DIV_MIN) and raises div_pend; the
// pending value moves into div_act only when the parent signals apply
// (period wrap while running, or any edge while disabled).
// Ports:
//   clk_in   : system clock
//   rst      : synchronous active-high reset
//   apply    : parent says a new divisor may take effect at this edge
//   div_wr   : one-cycle write strobe
//   div_val  : requested divisor
//   div_act  : divisor currently in use
//   div_pend : a written divisor is waiting to be applied
module prescaler_div_shadow
   import prescaler_prog_pkg::*;
#(
   parameter int unsigned N           = 24,
   parameter int unsigned DEFAULT_DIV = 12000000
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic         apply,
   input  logic         div_wr,
   input  logic [N-1:0] div_val,
   output logic [N-1:0] div_act,
   output logic         div_pend
);

   localparam longint unsigned DIV_MAX = (64'd1 << N) - 64'd1;

   // Reject a reset divisor outside [DIV_MIN, 2^N-1] at elaboration.
   if ((DEFAULT_DIV < DIV_MIN) || (64'(DEFAULT_DIV) > DIV_MAX)) begin : g_bad_default
      $error("prescaler_div_shadow: DEFAULT_DIV out of legal range");
   end

   logic [N-1:0] div_nxt;
   logic [N-1:0] div_clamp;

   // Divisors of 0 and 1 are meaningless for the counter; force them to 2.
   assign div_clamp = (div_val < N'(DIV_MIN)) ? N'(DIV_MIN) : div_val;

   // Apply uses the pre-edge shadow; a same-edge write is ordered last so it
   // re-arms pending for the following apply point.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         div_act  <= N'(DEFAULT_DIV);
         div_nxt  <= N'(DEFAULT_DIV);
         div_pend <= 1'b0;
      end else begin
         if (apply && div_pend) begin
            div_act  <= div_nxt;
            div_pend <= 1'b0;
         end
         if (div_wr) begin
            div_nxt  <= div_clamp;
            div_pend <= 1'b1;
         end
      end
   end

endmodule : prescaler_div_shadow

// File: rtl/prescaler_prog.sv
// Runtime-programmable clock prescaler / tick generator.
// Divides clk_in by D in [2, 2^N-1]; D is shadowed and switches only at a
// period boundary (or while disabled).
// Ports:
//   clk_in   : system clock, all logic on its rising edge
//   rst      : synchronous active-high reset
//   ena      : run enable; low holds the divider cleared
//   mode     : clk_out select, 0 = square wave, 1 = tick pulse
//   div_wr   : one-cycle strobe writing div_val to the shadow register
//   div_val  : requested divisor
//   clk_out  : divided output selected by mode
//   tick     : one-cycle pulse once per period
//   div_pend : a written divisor is waiting to be applied
module prescaler_prog
   import prescaler_prog_pkg::*;
#(
   parameter int unsigned N           = 24,
   parameter int unsigned DEFAULT_DIV = 12000000
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic         ena,
   input  logic         mode,
   input  logic         div_wr,
   input  logic [N-1:0] div_val,
   output logic         clk_out,
   output logic         tick,
   output logic         div_pend
);

   logic [N-1:0] count;
   logic [N-1:0] count_inc;
   logic [N-1:0] div_act;
   logic         sq;
   logic         wrap;
   logic         apply;

   // div_act >= 2, so div_act-1 never underflows.
   assign wrap      = (count == (div_act - N'(1)));
   assign count_inc = count + N'(1);
   assign apply     = (~ena) | wrap;

   prescaler_div_shadow #(
      .N           (N),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_div_shadow (
      .clk_in   (clk_in),
      .rst      (rst),
      .apply    (apply),
      .div_wr   (div_wr),
      .div_val  (div_val),
      .div_act  (div_act),
      .div_pend (div_pend)
   );

   // Counter, square and tick. sq is computed from the next count so that
   // sq == (count >= div_act/2) holds in every running cycle; at a wrap the
   // next count is 0, which is below D/2 for any D >= 2, even if D changes.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         count <= '0;
         sq    <= 1'b0;
         tick  <= 1'b0;
      end else if (!ena) begin
         count <= '0;
         sq    <= 1'b0;
         tick  <= 1'b0;
      end else if (wrap) begin
         count <= '0;
         sq    <= 1'b0;
         tick  <= 1'b1;
      end else begin
         count <= count_inc;
         sq    <= (count_inc >= (div_act >> 1));
         tick  <= 1'b0;
      end
   end

   // Combinational select of registered sources; mode acts immediately.
   assign clk_out = (mode_e'(mode) == MODE_TICK) ? tick : sq;

endmodule : prescaler_prog

// File: tb/tb_prescaler_prog.sv
// Scoreboard bench for prescaler_prog: stimulus pushes the expected outputs
// after each edge, a negedge monitor pops and compares.
module tb_prescaler_prog;

   localparam int unsigned N   = 8;
   localparam int unsigned DEF = 4;

   logic         clk_in = 1'b0;
   logic         rst    = 1'b1;
   logic         ena    = 1'b0;
   logic         mode   = 1'b0;
   logic         div_wr = 1'b0;
   logic [N-1:0] div_val = '0;
   logic         clk_out;
   logic         tick;
   logic         div_pend;

   prescaler_prog #(.N(N), .DEFAULT_DIV(DEF)) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .ena      (ena),
      .mode     (mode),
      .div_wr   (div_wr),
      .div_val  (div_val),
      .clk_out  (clk_out),
      .tick     (tick),
      .div_pend (div_pend)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic sq;
      logic tk;
      logic pend;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   stim_done = 1'b0;

   // Reference model: position within the current period, divisor in use,
   // shadow divisor and pending flag.
   int m_pos  = 0;
   int m_div  = DEF;
   int m_nxt  = DEF;
   int m_pend = 0;
   int m_tick = 0;
   int m_sq   = 0;

   task automatic model_edge(input logic r, input logic e, input logic w, input int v);
      if (r) begin
         m_pos = 0; m_div = DEF; m_nxt = DEF; m_pend = 0; m_tick = 0; m_sq = 0;
      end else begin
         if (e) begin
            if (m_pos == m_div - 1) begin
               m_pos  = 0;
               m_tick = 1;
               if (m_pend != 0) begin m_div = m_nxt; m_pend = 0; end
            end else begin
               m_pos  = m_pos + 1;
               m_tick = 0;
            end
            m_sq = (m_pos >= m_div / 2) ? 1 : 0;
         end else begin
            m_pos = 0; m_tick = 0; m_sq = 0;
            if (m_pend != 0) begin m_div = m_nxt; m_pend = 0; end
         end
         if (w) begin
            m_nxt  = (v < 2) ? 2 : v;
            m_pend = 1;
         end
      end
   endtask

   // One clock: drive inputs, let the edge happen, record expectation.
   task automatic step(input logic r, input logic e, input logic m, input logic w, input int v);
      exp_t x;
      rst = r; ena = e; mode = m; div_wr = w; div_val = N'(v);
      @(posedge clk_in);
      model_edge(r, e, w, v);
      x.sq = (m_sq != 0); x.tk = (m_tick != 0); x.pend = (m_pend != 0);
      exp_q.push_back(x);
      #1;
   endtask

   task automatic run(input int cycles, input logic m);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, m, 1'b0, 0);
   endtask

   // Advance (running) until the model sits at the given period position.
   task automatic run_to_pos(input int pos, input logic m);
      for (int i = 0; i < 600 && m_pos != pos; i++) step(1'b0, 1'b1, m, 1'b0, 0);
   endtask

   task automatic check(input string name, input logic act, input logic req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
      end
   endtask

   // Monitor: one expectation per edge, compared mid-cycle.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk_in);
         if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            check("tick", tick, x.tk);
            check("div_pend", div_pend, x.pend);
            check("clk_out", clk_out, mode ? x.tk : x.sq);
         end
      end
   end

   initial begin
      // Reset, then default divisor 4 in square mode.
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      run(14, 1'b0);

      // D=5: tick mode then square mode.
      step(1'b0, 1'b1, 1'b0, 1'b1, 5);
      run(12, 1'b1);
      run(10, 1'b0);

      // Back to D=4, then write 6 at count=1, then 8 in the wrap cycle.
      step(1'b0, 1'b1, 1'b0, 1'b1, 4);
      run(12, 1'b0);
      run_to_pos(1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 6);
      run_to_pos(3, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8);
      run(20, 1'b0);

      // Write 0 while disabled: clamps to 2.
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      run(8, 1'b0);
      run(6, 1'b1);

      // Reset mid-period with a write pending.
      step(1'b0, 1'b1, 1'b0, 1'b1, 9);
      run_to_pos(0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 7);
      step(1'b0, 1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      run(10, 1'b0);

      // Large divisor once, including the top of the range.
      step(1'b0, 1'b1, 1'b0, 1'b1, 255);
      run(600, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 3);
      run(300, 1'b1);

      // Randomised traffic.
      begin
         logic e = 1'b1;
         logic m = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            logic r, w;
            int   v;
            r = ($urandom_range(0, 399) == 0);
            w = ($urandom_range(0, 14) == 0);
            v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
            if ($urandom_range(0, 39) == 0) e = ~e;
            if ($urandom_range(0, 29) == 0) m = ~m;
            step(r, e, m, w, v);
         end
      end

      step(1'b0, 1'b0, 1'b0, 1'b0, 0);
      repeat (3) @(negedge clk_in);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      stim_done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_prescaler_prog

// File: doc/prescaler_prog.md
Name: prescaler_prog

Overview:
Runtime-programmable clock prescaler and tick generator. It is the parametrised successor of the fixed power-of-two prescaler, which is limited to a 2^N period.
- Divides clk_in by any integer D in [2, 2^N-1].
- Emits either a near-50% square wave or a single-cycle tick on clk_out; a tick strobe is always available separately.
- Divisor updates are glitch-free: a new value is shadowed and takes effect only at a period boundary.
- Feeds LED blinkers, UART baud-tick and scan-rate logic across the board designs.

Parameters:
N, 24, counter and divisor width in bits.
DEFAULT_DIV, 12000000, divisor loaded at reset; legal range [2, 2^N-1]; default gives 1 Hz from 12 MHz.

Ports:
clk_in  input  1  system clock; all logic on its rising edge.
rst  input  1  reset, synchronous, active-high.
ena  input  1  run enable; 0 holds the divider cleared.
mode  input  1  clk_out select: 0 = square wave, 1 = tick pulse.
div_wr  input  1  one-cycle strobe that writes div_val into the shadow register.
div_val  input  N  requested divisor.
clk_out  output  1  divided output, selected by mode.
tick  output  1  one-cycle pulse, once per period.
div_pend  output  1  high while a written divisor is waiting to be applied.

Behaviour:
- Internal state:
  - count[N-1:0], range 0..D-1.
  - div_act, the active divisor D.
  - div_nxt, the shadow divisor.
  - div_pend, sq, tick registers.
- Reset (rst=1 at an edge) has priority over every other input. Result: count=0, div_act=div_nxt=DEFAULT_DIV, div_pend=0, sq=0, tick=0.
- Write:
  - On an edge with div_wr=1: div_nxt <= max(div_val, 2), so values 0 and 1 clamp to 2; div_pend <= 1.
  - A write while already pending overwrites div_nxt; the last write wins.
- Run (ena=1, no reset):
  - If count == div_act-1 (wrap): count <= 0 and tick <= 1.
    - If div_pend was 1 before this edge, div_act <= div_nxt and div_pend <= 0.
  - Otherwise: count <= count+1 and tick <= 0.
- Simultaneous wrap and div_wr:
  - The value applied at this wrap is the div_nxt held before the edge, and only if a write was already pending.
  - The newly written value lands in div_nxt with div_pend=1 and is applied at the following wrap.
- Disabled (ena=0, no reset):
  - count <= 0, tick <= 0, sq <= 0.
  - If pending, div_act <= div_nxt and div_pend <= 0 at this edge. A div_wr in the same cycle still goes to the shadow and sets pending.
- Square output:
  - sq is updated on every edge together with count, so that sq == (count >= (div_act >> 1)) holds in every cycle while ena=1.
  - Result: low for floor(D/2) cycles, then high for ceil(D/2) cycles. Odd D gives the extra cycle to the high phase.
  - sq is 0 after reset and while disabled.
- Tick timing: tick is high for exactly one cycle, the cycle in which count==0 immediately after a wrap. It is not asserted on the first count==0 after reset or after ena rises.
- Latency: first tick occurs D cycles after ena rises with count=0. Period is exactly D cycles thereafter.
- clk_out = mode ? tick : sq. This is a combinational mux of registered signals; a mode change takes effect in the same cycle.
- Width rules:
  - Comparison count == div_act-1 is done at N bits; div_act >= 2 guarantees no underflow.
  - DEFAULT_DIV outside the legal range is a parameter error, flagged by an elaboration-time check.

Decomposition:
- Shared package/include holds: MODE_SQUARE=0, MODE_TICK=1, DIV_MIN=2.
- One natural sub-module: prescaler_div_shadow. It owns div_nxt, div_pend, the clamp and the apply-on-wrap/ena-low handshake, and outputs div_act.
- The counter, sq and tick logic stay in the top module.

Test Plan:
- Reset, then DEFAULT_DIV overridden to 4, ena=1, mode=0 -> count 0,1,2,3,0…; sq 0,0,1,1 repeating; tick high only in the count==0 cycle after each wrap, first one 4 cycles after ena rises.
- D=5, mode=1 -> clk_out pulses 1 cycle every 5; with mode=0, sq low 2 cycles, high 3.
- D=4 running; div_wr div_val=6 at count=1 -> div_pend=1 until the wrap edge; next period is 6 cycles and div_pend=0; no short or long sq phase at the switch.
- div_wr div_val=8 in the exact wrap cycle while div_pend=1 holding 6 -> 6 is applied at this wrap; 8 is applied at the next wrap.
- div_wr div_val=0 while ena=0 -> div_act=2 at the next edge, div_pend=0; on ena=1, tick every 2 cycles and sq alternates 0,1.
- rst asserted mid-period with a divisor pending -> next cycle count=0, sq=0, tick=0, div_pend=0, div_act=DEFAULT_DIV.
